// File: rtl/uart_rx_queue_pkg.sv
// Shared definitions for the UART receive queue: FSM encodings and queue sizing.
package uart_rx_queue_pkg;

  localparam logic [1:0] UQ_IDLE    = 2'd0;
  localparam logic [1:0] UQ_REQ     = 2'd1;
  localparam logic [1:0] UQ_STROBE  = 2'd2;
  localparam logic [1:0] UQ_RELEASE = 2'd3;

  // Queue depth derived from the pointer width so every user agrees on it.
  function automatic int queue_size(input int log2);
    return 1 << log2;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Generic circular buffer with a separate occupancy count so full and empty
// are unambiguous when the pointers are equal.
module uart_rx_fifo
  import uart_rx_queue_pkg::*;
#(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] front_data,
  output logic [AW-1:0] front,
  output logic [AW-1:0] tail,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = queue_size(AW);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = pop && !empty;
  // A push into a full queue is only accepted when a pop frees a slot on the same edge.
  assign do_push = push && (!full || do_pop);

  assign front_data = mem[front];

  always_ff @(posedge clk) begin
    if (!rst) begin
      front <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_pop)  front <= front + AW'(1);
      if (do_push) tail  <= tail + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= push_data;
  end

endmodule

// File: rtl/uart_rx_queue.sv
// Receive-side buffer: syncs the UART chip's data_ready, borrows the shared
// RAM1 bus, strobes rdn low to read a byte, and queues it for the controller.
module uart_rx_queue
  import uart_rx_queue_pkg::*;
#(
  parameter int QDEPTH_LOG2    = 4,
  parameter int RDN_LOW_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   data_ready,
  output logic                   rdn,
  input  logic [7:0]             bus_data,
  output logic                   bus_req,
  input  logic                   bus_grant,
  input  logic                   pop,
  output logic [15:0]            pop_data,
  output logic                   empty,
  output logic                   full,
  output logic [QDEPTH_LOG2:0]   count,
  output logic [QDEPTH_LOG2-1:0] front,
  output logic [QDEPTH_LOG2-1:0] tail,
  output logic [1:0]             dbg_state
);

  logic       sync1;
  logic       dr_s;
  logic [1:0] state;
  logic [3:0] strobe_cnt;
  logic       sample;
  logic [7:0] front_byte;

  assign dbg_state = state;
  assign sample    = (state == UQ_STROBE) && (strobe_cnt == 4'(RDN_LOW_CYCLES - 1));
  assign pop_data  = empty ? 16'h0000 : {8'h00, front_byte};

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= 1'b0;
      dr_s  <= 1'b0;
    end else begin
      sync1 <= data_ready;
      dr_s  <= sync1;
    end
  end

  // Bus handshake: bus_req rises in REQ and stays high until the byte is
  // sampled; bus_grant is consulted only in REQ and the arbiter keeps it high
  // for as long as bus_req is high, so a grant is never lost mid-strobe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= UQ_IDLE;
      rdn        <= 1'b1;
      bus_req    <= 1'b0;
      strobe_cnt <= 4'd0;
    end else begin
      case (state)
        UQ_IDLE: begin
          if (dr_s && !full) begin
            state   <= UQ_REQ;
            bus_req <= 1'b1;
          end
        end
        UQ_REQ: begin
          if (bus_grant) begin
            state      <= UQ_STROBE;
            rdn        <= 1'b0;
            strobe_cnt <= 4'd0;
          end
        end
        UQ_STROBE: begin
          strobe_cnt <= strobe_cnt + 4'd1;
          if (sample) begin
            state   <= UQ_RELEASE;
            rdn     <= 1'b1;
            bus_req <= 1'b0;
          end
        end
        UQ_RELEASE: begin
          // Wait for the synchronized flag to clear so one byte is never read twice.
          if (!dr_s) state <= UQ_IDLE;
        end
        default: state <= UQ_IDLE;
      endcase
    end
  end

  uart_rx_fifo #(
    .AW (QDEPTH_LOG2),
    .DW (8)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (sample),
    .push_data  (bus_data),
    .pop        (pop),
    .front_data (front_byte),
    .front      (front),
    .tail       (tail),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

endmodule

// File: tb/tb_uart_rx_queue.sv
// Bench for uart_rx_queue: directed scenarios plus random traffic checked
// against a byte-queue reference model.
module tb_uart_rx_queue;

  localparam int QL   = 4;
  localparam int RDN  = 2;
  localparam int QDEP = 16;

  logic          clk;
  logic          rst;
  logic          data_ready;
  logic          rdn;
  logic [7:0]    bus_data;
  logic          bus_req;
  logic          bus_grant;
  logic          pop;
  logic [15:0]   pop_data;
  logic          empty;
  logic          full;
  logic [QL:0]   count;
  logic [QL-1:0] front;
  logic [QL-1:0] tail;
  logic [1:0]    dbg_state;

  int n_checks;
  int n_errors;

  logic [7:0] exp_q[$];
  int         n_push;
  int         n_pop;

  uart_rx_queue #(
    .QDEPTH_LOG2    (QL),
    .RDN_LOW_CYCLES (RDN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_ready (data_ready),
    .rdn        (rdn),
    .bus_data   (bus_data),
    .bus_req    (bus_req),
    .bus_grant  (bus_grant),
    .pop        (pop),
    .pop_data   (pop_data),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .front      (front),
    .tail       (tail),
    .dbg_state  (dbg_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_front();
    return (exp_q.size() == 0) ? 16'h0000 : {8'h00, exp_q[0]};
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_count"}, 32'(count), exp_q.size());
    check({tag, "_empty"}, 32'(empty), (exp_q.size() == 0) ? 1 : 0);
    check({tag, "_full"},  32'(full),  (exp_q.size() == QDEP) ? 1 : 0);
    check({tag, "_front"}, 32'(front), n_pop % QDEP);
    check({tag, "_tail"},  32'(tail),  n_push % QDEP);
    check({tag, "_pdata"}, 32'(pop_data), 32'(model_front()));
  endtask

  // driver tasks
  task automatic do_reset();
    rst = 1'b0;
    data_ready = 1'b0;
    pop = 1'b0;
    bus_grant = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    exp_q.delete();
    n_push = 0;
    n_pop = 0;
    check("rst_rdn", 32'(rdn), 1);
    check("rst_req", 32'(bus_req), 0);
    check("rst_state", 32'(dbg_state), 0);
    check_state("rst");
    tick();
  endtask

  task automatic do_pop();
    check("pop_data_pre", 32'(pop_data), 32'(model_front()));
    pop = 1'b1;
    tick();
    pop = 1'b0;
    if (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      n_pop++;
    end
    check_state("pop");
  endtask

  // Waits for the strobe, measures its width and records the byte read.
  task automatic capture_strobe(input logic [7:0] b, input bit pp);
    int w;
    int lo;
    w = 0;
    while (rdn !== 1'b0 && w < 20) begin
      tick();
      w++;
    end
    check("strobe_seen", 32'(rdn), 0);
    lo = 0;
    while (rdn === 1'b0 && lo < 20) begin
      lo++;
      if (pp && lo == RDN) begin
        check("simul_pop_data", 32'(pop_data), 32'(model_front()));
        pop = 1'b1;
      end
      tick();
      pop = 1'b0;
    end
    check("rdn_low_len", lo, RDN);
    if (pp && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      n_pop++;
    end
    exp_q.push_back(b);
    n_push++;
  endtask

  task automatic release_ready(input int hold);
    bus_grant = 1'b0;
    for (int i = 0; i < hold; i++) begin
      check("hold_req", 32'(bus_req), 0);
      check("hold_rdn", 32'(rdn), 1);
      tick();
    end
    data_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("settle_rdn", 32'(rdn), 1);
    end
    check_state("send");
  endtask

  task automatic send_byte(input logic [7:0] b, input int gd, input int hold, input bit pp);
    int t;
    bus_data = b;
    data_ready = 1'b1;
    bus_grant = (gd == 0);
    t = 0;
    while (bus_req !== 1'b1 && t < 40) begin
      check("idle_rdn", 32'(rdn), 1);
      tick();
      t++;
    end
    check("req_latency", t, 3);
    for (int i = 0; i < gd; i++) begin
      check("grant_wait_rdn", 32'(rdn), 1);
      tick();
    end
    bus_grant = 1'b1;
    tick();
    check("strobe_start", 32'(rdn), 0);
    capture_strobe(b, pp);
    release_ready(hold);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    bus_data = 8'h00;
    do_reset();

    // single byte
    send_byte(8'h5A, 0, 0, 0);
    check("single_pdata", 32'(pop_data), 32'h005A);
    do_pop();
    check("single_empty", 32'(empty), 1);

    // grant delay
    send_byte(8'hC3, 5, 0, 0);
    do_pop();

    // fill and wrap
    do_reset();
    for (int i = 0; i < QDEP; i++) send_byte(8'(i), 0, 0, 0);
    check("fill_full", 32'(full), 1);
    check("fill_count", 32'(count), 16);
    bus_data = 8'hA7;
    data_ready = 1'b1;
    bus_grant = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("blocked_req", 32'(bus_req), 0);
      check("blocked_rdn", 32'(rdn), 1);
    end
    do_pop();
    capture_strobe(8'hA7, 0);
    release_ready(0);
    check("wrap_tail", 32'(tail), 1);
    while (exp_q.size() > 0) do_pop();

    // simultaneous push and pop
    do_reset();
    for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)), 0, 0, 0);
    send_byte(8'($urandom_range(0, 255)), 0, 0, 1);
    check("simul_count", 32'(count), 3);
    check("simul_front", 32'(front), 1);
    check("simul_tail", 32'(tail), 4);

    // reset mid-strobe
    do_reset();
    bus_data = 8'h99;
    data_ready = 1'b1;
    bus_grant = 1'b1;
    for (int i = 0; i < 20 && rdn !== 1'b0; i++) tick();
    check("mid_strobe_seen", 32'(rdn), 0);
    rst = 1'b0;
    tick();
    check("mid_rst_rdn", 32'(rdn), 1);
    check("mid_rst_req", 32'(bus_req), 0);
    check("mid_rst_count", 32'(count), 0);
    check("mid_rst_tail", 32'(tail), 0);
    data_ready = 1'b0;
    bus_grant = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    n_push = 0;
    n_pop = 0;
    for (int i = 0; i < 5; i++) tick();
    check_state("mid_rst");

    // no double read
    send_byte(8'h3C, 0, 3, 0);
    check("no_double_count", 32'(count), 1);

    // random traffic, including pops while empty
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 1 && exp_q.size() < QDEP)
        send_byte(8'($urandom_range(0, 255)), $urandom_range(0, 3), $urandom_range(0, 3), 0);
      else
        do_pop();
    end
    while (exp_q.size() > 0) do_pop();
    do_pop();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
